// File: rtl/dpram_tap_reader_pkg.sv
// rtl/dpram_tap_reader_pkg.sv - shared state encoding and FIFO sizing for the tap reader
package dpram_tap_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  // A new read may issue only while buffered words plus outstanding reads stay below this
  localparam logic [OCC_W:0] CREDIT_LIMIT = (OCC_W + 1)'(FIFO_DEPTH);

endpackage

// File: rtl/dpram_tap_fifo.sv
// rtl/dpram_tap_fifo.sv - 4-entry shift FIFO whose head entry is a plain register
module dpram_tap_fifo
  import dpram_tap_reader_pkg::*;
#(
  parameter int W = 17
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [OCC_W-1:0] occ,
  output logic             valid
);

  logic [W-1:0]     ent [FIFO_DEPTH];
  logic [OCC_W-1:0] wpos;

  // On a simultaneous pop the entries shift down, so the free slot is one lower
  assign wpos  = occ - OCC_W'(pop);
  assign head  = ent[0];
  assign valid = (occ != '0);

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      occ <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) ent[k] <= '0;
    end else begin
      if (pop) begin
        for (int k = 0; k < FIFO_DEPTH - 1; k++) ent[k] <= ent[k+1];
      end
      if (push) ent[wpos[PTR_W-1:0]] <= din;
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end

endmodule

// File: rtl/dpram_tap_reader.sv
// rtl/dpram_tap_reader.sv - walks COUNT RAM taps newest-first into a valid/ready stream
// Optional out_index port enabled by DPRAM_TAP_READER_INDEX_EN.
module dpram_tap_reader
  import dpram_tap_reader_pkg::*;
#(
  parameter int BITS   = 16,
  parameter int SIZE   = 256,
  parameter int AWIDTH = $clog2(SIZE)
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base,
  input  logic [AWIDTH:0]   count,
  output logic              re,
  output logic [AWIDTH-1:0] raddr,
  input  logic [BITS-1:0]   rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITS-1:0]   out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef DPRAM_TAP_READER_INDEX_EN
  ,
  output logic [AWIDTH:0]   out_index
`endif
);

  localparam logic [AWIDTH:0]   ONE  = (AWIDTH + 1)'(1);
  localparam logic [AWIDTH-1:0] STEP = AWIDTH'(1);
`ifdef DPRAM_TAP_READER_INDEX_EN
  localparam int TW = BITS + 1 + AWIDTH + 1;
`else
  localparam int TW = BITS + 1;
`endif

  state_t           state;
  logic [AWIDTH:0]  cnt;
  logic [AWIDTH:0]  issued;
  logic [AWIDTH:0]  issued_nx;
  logic             pend;
  logic             last_q;
  logic             last_p;
  logic [TW-1:0]    din;
  logic [TW-1:0]    head;
  logic [OCC_W-1:0] occ;
  logic             pop;
  logic [OCC_W:0]   load;
`ifdef DPRAM_TAP_READER_INDEX_EN
  logic [AWIDTH:0]  idx_q;
  logic [AWIDTH:0]  idx_p;
`endif

  assign pop       = out_valid & out_ready;
  assign issued_nx = issued + ONE;
  // Next cycle's FIFO occupancy plus the read that will be in its rdata cycle
  assign load = {1'b0, occ} + (OCC_W + 1)'(pend) + (OCC_W + 1)'(re) - (OCC_W + 1)'(pop);

`ifdef DPRAM_TAP_READER_INDEX_EN
  assign din = {idx_p, last_p, rdata};
  assign {out_index, out_last, out_data} = head;
`else
  assign din = {last_p, rdata};
  assign {out_last, out_data} = head;
`endif

  dpram_tap_fifo #(.W(TW)) u_fifo (
    .ck    (ck),
    .rst_n (rst_n),
    .push  (pend),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .occ   (occ),
    .valid (out_valid)
  );

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      state  <= IDLE;
      re     <= 1'b0;
      raddr  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      issued <= '0;
      pend   <= 1'b0;
      last_q <= 1'b0;
      last_p <= 1'b0;
`ifdef DPRAM_TAP_READER_INDEX_EN
      idx_q  <= '0;
      idx_p  <= '0;
`endif
    end else begin
      pend   <= re;
      last_p <= last_q;
`ifdef DPRAM_TAP_READER_INDEX_EN
      idx_p  <= idx_q;
`endif
      done   <= 1'b0;
      case (state)
        IDLE: begin
          re <= 1'b0;
          if (start) begin
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              // The FIFO is empty in IDLE, so the first read issues immediately
              cnt    <= count;
              busy   <= 1'b1;
              re     <= 1'b1;
              raddr  <= base;
              last_q <= (count == ONE);
              issued <= ONE;
`ifdef DPRAM_TAP_READER_INDEX_EN
              idx_q  <= '0;
`endif
              state  <= (count == ONE) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (load < CREDIT_LIMIT) begin
            re     <= 1'b1;
            raddr  <= raddr - STEP;
            last_q <= (issued_nx == cnt);
            issued <= issued_nx;
`ifdef DPRAM_TAP_READER_INDEX_EN
            idx_q  <= issued;
`endif
            if (issued_nx == cnt) state <= DRAIN;
          end else begin
            re <= 1'b0;
          end
        end
        DRAIN: begin
          re <= 1'b0;
          if (pop && out_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_tap_reader.sv
// tb/tb_dpram_tap_reader.sv - randomized self-checking bench for dpram_tap_reader
module tb_dpram_tap_reader;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  base = '0;
  logic [4:0]  count = '0;
  logic        re;
  logic [3:0]  raddr;
  logic [15:0] rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef DPRAM_TAP_READER_INDEX_EN
  logic [4:0]  out_index;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] ram [16];
  logic [15:0] w_data [$];
  bit          w_last [$];
  int          w_cyc  [$];
  int          w_idx  [$];
  logic [3:0]  a_q    [$];
  int          d_q    [$];
  int          stall_err = 0;
  int          credit_err = 0;
  int          outstanding = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;

  dpram_tap_reader #(.BITS(16), .SIZE(16)) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .start     (start),
    .base      (base),
    .count     (count),
    .re        (re),
    .raddr     (raddr),
    .rdata     (rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef DPRAM_TAP_READER_INDEX_EN
    ,
    .out_index (out_index)
`endif
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  initial for (int i = 0; i < 16; i++) ram[i] = 16'h100 + 16'(i);
  always @(posedge ck) if (re) rdata <= ram[raddr];

  // Reference: tap i of a run is the sample at (base - i) mod 16
  function automatic logic [3:0] ref_addr(int b, int i);
    return 4'((((b - i) % 16) + 16) % 16);
  endfunction

  function automatic logic [15:0] ref_word(int b, int i);
    return 16'h100 + 16'(ref_addr(b, i));
  endfunction

  // Stream observer: accepted words, issued addresses, done cycles, protocol violations
  always @(negedge ck) begin
    if (!rst_n) begin
      outstanding = 0;
      prev_stall  = 0;
    end else begin
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
        stall_err++;
      if (re) begin
        a_q.push_back(raddr);
        if (outstanding >= 4) credit_err++;
      end
      if (out_valid && out_ready) begin
        w_data.push_back(out_data);
        w_last.push_back(out_last);
        w_cyc.push_back(cyc);
`ifdef DPRAM_TAP_READER_INDEX_EN
        w_idx.push_back(int'(out_index));
`endif
      end
      if (done) d_q.push_back(cyc);
      outstanding = outstanding + int'(re) - int'(out_valid && out_ready);
      prev_stall  = out_valid && !out_ready;
      prev_data   = out_data;
      prev_last   = out_last;
    end
  end

  task automatic clear_obs;
    w_data.delete(); w_last.delete(); w_cyc.delete(); w_idx.delete();
    a_q.delete(); d_q.delete();
    stall_err = 0; credit_err = 0;
  endtask

  // mode 0: out_ready=1, mode 1: toggling 1,0,1,..., mode 2: random
  task automatic drive_run(input int b, input int n, input int mode, output int t0, output bit ok);
    clear_obs();
    @(posedge ck); #2;
    start = 1'b1; base = 4'(b); count = 5'(n); out_ready = 1'b1; t0 = cyc;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge ck); #2;
      start = 1'b0; base = 4'($urandom); count = 5'($urandom);
      if (mode == 1) out_ready = ~out_ready;
      else if (mode == 2) out_ready = 1'($urandom);
      if (d_q.size() != 0) begin ok = 1; break; end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge ck);
    #2;
    n_chk++; if (re !== 1'b0) begin n_err++; $display("FAIL reset_re: got %b want 0", re); end
    n_chk++; if (raddr !== 4'd0) begin n_err++; $display("FAIL reset_raddr: got %0d want 0", raddr); end
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_chk++; if (out_data !== 16'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_chk++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
`ifdef DPRAM_TAP_READER_INDEX_EN
    n_chk++; if (out_index !== 5'd0) begin n_err++; $display("FAIL reset_out_index: got %0d want 0", out_index); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int t0; bit ok;
    drive_run(5, 4, 0, t0, ok);
    n_chk++; if (ok !== 1'b1) begin n_err++; $display("FAIL basic_timeout: got %0d want 1", ok); end
    n_chk++; if (w_data.size() != 4) begin n_err++; $display("FAIL basic_words: got %0d want 4", w_data.size()); end
    for (int i = 0; i < w_data.size() && i < 4; i++) begin
      n_chk++; if (w_data[i] !== ref_word(5, i)) begin n_err++; $display("FAIL basic_data[%0d]: got %h want %h", i, w_data[i], ref_word(5, i)); end
      n_chk++; if (w_cyc[i] != t0 + 3 + i) begin n_err++; $display("FAIL basic_cycle[%0d]: got %0d want %0d", i, w_cyc[i] - t0, 3 + i); end
      n_chk++; if (w_last[i] != (i == 3)) begin n_err++; $display("FAIL basic_last[%0d]: got %0d want %0d", i, w_last[i], i == 3); end
`ifdef DPRAM_TAP_READER_INDEX_EN
      n_chk++; if (w_idx[i] != i) begin n_err++; $display("FAIL basic_index[%0d]: got %0d want %0d", i, w_idx[i], i); end
`endif
    end
    n_chk++; if (d_q.size() == 0 || d_q[0] != t0 + 7) begin n_err++; $display("FAIL basic_done_cycle: got %0d want %0d", d_q.size() ? d_q[0] - t0 : -1, 7); end
  endtask

  task automatic test_wrap;
    int t0; bit ok;
    drive_run(1, 4, 0, t0, ok);
    n_chk++; if (ok !== 1'b1) begin n_err++; $display("FAIL wrap_timeout: got %0d want 1", ok); end
    n_chk++; if (w_data.size() != 4 || a_q.size() != 4) begin n_err++; $display("FAIL wrap_count: got %0d/%0d want 4/4", w_data.size(), a_q.size()); end
    for (int i = 0; i < w_data.size() && i < 4; i++) begin
      n_chk++; if (w_data[i] !== ref_word(1, i)) begin n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", i, w_data[i], ref_word(1, i)); end
    end
    for (int i = 0; i < a_q.size() && i < 4; i++) begin
      n_chk++; if (a_q[i] !== ref_addr(1, i)) begin n_err++; $display("FAIL wrap_raddr[%0d]: got %0d want %0d", i, a_q[i], ref_addr(1, i)); end
    end
  endtask

  task automatic test_backpressure;
    int t0; bit ok;
    drive_run(9, 8, 1, t0, ok);
    n_chk++; if (ok !== 1'b1) begin n_err++; $display("FAIL bp_timeout: got %0d want 1", ok); end
    n_chk++; if (w_data.size() != 8) begin n_err++; $display("FAIL bp_words: got %0d want 8", w_data.size()); end
    for (int i = 0; i < w_data.size() && i < 8; i++) begin
      n_chk++; if (w_data[i] !== ref_word(9, i) || w_last[i] != (i == 7)) begin n_err++; $display("FAIL bp_word[%0d]: got %h/%0d want %h/%0d", i, w_data[i], w_last[i], ref_word(9, i), i == 7); end
`ifdef DPRAM_TAP_READER_INDEX_EN
      n_chk++; if (w_idx[i] != i) begin n_err++; $display("FAIL bp_index[%0d]: got %0d want %0d", i, w_idx[i], i); end
`endif
    end
    n_chk++; if (stall_err != 0) begin n_err++; $display("FAIL bp_stable: got %0d violations want 0", stall_err); end
    n_chk++; if (credit_err != 0) begin n_err++; $display("FAIL bp_credit: got %0d violations want 0", credit_err); end
  endtask

  task automatic test_full;
    int t0; bit ok;
    drive_run(0, 16, 0, t0, ok);
    n_chk++; if (ok !== 1'b1) begin n_err++; $display("FAIL full_timeout: got %0d want 1", ok); end
    n_chk++; if (w_data.size() != 16 || a_q.size() != 16) begin n_err++; $display("FAIL full_count: got %0d/%0d want 16/16", w_data.size(), a_q.size()); end
    for (int i = 0; i < w_data.size() && i < 16; i++) begin
      n_chk++; if (w_data[i] !== ref_word(0, i)) begin n_err++; $display("FAIL full_data[%0d]: got %h want %h", i, w_data[i], ref_word(0, i)); end
    end
    for (int i = 0; i < a_q.size() && i < 16; i++) begin
      n_chk++; if (a_q[i] !== ref_addr(0, i)) begin n_err++; $display("FAIL full_raddr[%0d]: got %0d want %0d", i, a_q[i], ref_addr(0, i)); end
    end
    n_chk++; if (d_q.size() == 0 || d_q[0] != t0 + 19) begin n_err++; $display("FAIL full_done_cycle: got %0d want 19", d_q.size() ? d_q[0] - t0 : -1); end
  endtask

  task automatic test_zero;
    int t0; bit ok;
    drive_run(7, 0, 0, t0, ok);
    n_chk++; if (ok !== 1'b1) begin n_err++; $display("FAIL zero_timeout: got %0d want 1", ok); end
    n_chk++; if (d_q.size() != 1 || d_q[0] != t0 + 1) begin n_err++; $display("FAIL zero_done: got %0d pulses at %0d want 1 at 1", d_q.size(), d_q.size() ? d_q[0] - t0 : -1); end
    n_chk++; if (a_q.size() != 0) begin n_err++; $display("FAIL zero_reads: got %0d want 0", a_q.size()); end
    n_chk++; if (w_data.size() != 0) begin n_err++; $display("FAIL zero_words: got %0d want 0", w_data.size()); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_midrun;
    int t0; bit ok;
    clear_obs();
    @(posedge ck); #2;
    start = 1'b1; base = 4'd5; count = 5'd8; out_ready = 1'b1;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge ck); #2;
      start = 1'b0;
      if (w_data.size() >= 2) begin ok = 1; break; end
    end
    n_chk++; if (ok !== 1'b1) begin n_err++; $display("FAIL midrun_wait: got %0d want 1", ok); end
    rst_n = 1'b0;
    @(posedge ck); #2;
    n_chk++; if (re !== 1'b0) begin n_err++; $display("FAIL midrun_re: got %b want 0", re); end
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrun_out_valid: got %b want 0", out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrun_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_err++; $display("FAIL midrun_done: got %b want 0", done); end
    rst_n = 1'b1;
    clear_obs();
    for (int k = 0; k < 4; k++) begin
      @(posedge ck); #2;
      n_chk++; if (out_valid !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midrun_quiet[%0d]: got valid=%b done=%b want 0/0", k, out_valid, done); end
    end
    drive_run(3, 2, 0, t0, ok);
    n_chk++; if (ok !== 1'b1) begin n_err++; $display("FAIL midrun_rerun_timeout: got %0d want 1", ok); end
    n_chk++; if (w_data.size() != 2) begin n_err++; $display("FAIL midrun_rerun_words: got %0d want 2", w_data.size()); end
    for (int i = 0; i < w_data.size() && i < 2; i++) begin
      n_chk++; if (w_data[i] !== ref_word(3, i)) begin n_err++; $display("FAIL midrun_rerun_data[%0d]: got %h want %h", i, w_data[i], ref_word(3, i)); end
    end
  endtask

  task automatic test_back_to_back;
    int t0; int t1; bit ok;
    logic [15:0] exp_w [$];
    clear_obs();
    for (int i = 0; i < 3; i++) exp_w.push_back(ref_word(5, i));
    for (int i = 0; i < 2; i++) exp_w.push_back(ref_word(12, i));
    @(posedge ck); #2;
    start = 1'b1; base = 4'd5; count = 5'd3; out_ready = 1'b1; t0 = cyc; t1 = -1;
    for (int k = 0; k < 100; k++) begin
      @(posedge ck); #2;
      if (done) begin
        start = 1'b1; base = 4'd12; count = 5'd2; t1 = cyc;
        break;
      end
      start = busy ? 1'($urandom) : 1'b0;
      base = 4'($urandom); count = 5'($urandom);
    end
    @(posedge ck); #2;
    start = 1'b0;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (d_q.size() >= 2) begin ok = 1; break; end
      @(posedge ck); #2;
    end
    n_chk++; if (t1 != t0 + 6) begin n_err++; $display("FAIL b2b_first_done: got %0d want %0d", t1 - t0, 6); end
    n_chk++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_timeout: got %0d want 1", ok); end
    n_chk++; if (w_data.size() != 5) begin n_err++; $display("FAIL b2b_words: got %0d want 5", w_data.size()); end
    for (int i = 0; i < w_data.size() && i < 5; i++) begin
      n_chk++; if (w_data[i] !== exp_w[i] || w_last[i] != (i == 2 || i == 4)) begin n_err++; $display("FAIL b2b_word[%0d]: got %h/%0d want %h/%0d", i, w_data[i], w_last[i], exp_w[i], i == 2 || i == 4); end
    end
    n_chk++; if (w_cyc.size() < 4 || w_cyc[3] != t1 + 3) begin n_err++; $display("FAIL b2b_second_latency: got %0d want 3", w_cyc.size() >= 4 ? w_cyc[3] - t1 : -1); end
    n_chk++; if (d_q.size() < 2 || d_q[1] != t1 + 5) begin n_err++; $display("FAIL b2b_second_done: got %0d want 5", d_q.size() >= 2 ? d_q[1] - t1 : -1); end
  endtask

  task automatic test_random;
    int t0; bit ok; int b; int n;
    for (int r = 0; r < 6; r++) begin
      b = int'($urandom_range(0, 15));
      n = int'($urandom_range(1, 16));
      drive_run(b, n, 2, t0, ok);
      n_chk++; if (ok !== 1'b1) begin n_err++; $display("FAIL rand%0d_timeout: got %0d want 1", r, ok); end
      n_chk++; if (w_data.size() != n) begin n_err++; $display("FAIL rand%0d_words: got %0d want %0d", r, w_data.size(), n); end
      for (int i = 0; i < w_data.size() && i < n; i++) begin
        n_chk++; if (w_data[i] !== ref_word(b, i) || w_last[i] != (i == n - 1)) begin n_err++; $display("FAIL rand%0d_word[%0d]: got %h/%0d want %h/%0d", r, i, w_data[i], w_last[i], ref_word(b, i), i == n - 1); end
`ifdef DPRAM_TAP_READER_INDEX_EN
        n_chk++; if (w_idx[i] != i) begin n_err++; $display("FAIL rand%0d_index[%0d]: got %0d want %0d", r, i, w_idx[i], i); end
`endif
      end
      n_chk++; if (stall_err != 0 || credit_err != 0) begin n_err++; $display("FAIL rand%0d_protocol: got stall=%0d credit=%0d want 0/0", r, stall_err, credit_err); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_full();
    test_zero();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
